// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the pmem port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {GNT_IFU, GNT_LSU} grant_t;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  localparam int TO_W_DEF   = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the pmem port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                ifu_req_valid;
  logic                ifu_req_ready;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_resp_valid;
  logic                ifu_resp_err;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                lsu_req_valid;
  logic                lsu_req_ready;
  logic [ADDR_W-1:0]   lsu_addr;
  logic                lsu_wen;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_resp_valid;
  logic                lsu_resp_err;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational IFU/LSU grant; MEM_ARB_ROUND_ROBIN_EN selects alternating
// priority on conflicts, otherwise LSU wins.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  grant_t last_grant,
`endif
  output logic   any_req,
  output grant_t grant
);

  always_comb begin
    any_req = ifu_valid | lsu_valid;
    grant   = lsu_valid ? GNT_LSU : GNT_IFU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ifu_valid && lsu_valid) begin
      grant = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end
`else
    if (ifu_valid && lsu_valid) begin
      grant = GNT_LSU;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding pmem port shared by IFU and LSU, with WAIT watchdog.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin conflict arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TO_W   = TO_W_DEF
)(
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              stray_resp
);

  // Last WAIT cycle before the watchdog fires: cnt is about to reach 2**TO_W-1.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'((2 ** TO_W) - 2);

  state_t              state_q, state_d;
  grant_t              grant_q, pick;
  logic                any_req;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [TO_W-1:0]     cnt_q;
  logic                timeout;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_t last_grant_q;
`endif

  mem_arb_picker u_picker (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .any_req    (any_req),
    .grant      (pick)
  );

  assign timeout = (cnt_q == CNT_LAST) && !bus.mem_resp_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (bus.mem_req_ready) state_d = WAIT;
      WAIT:    if (bus.mem_resp_valid || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GNT_IFU;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      stray_resp <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= GNT_IFU;
`endif
    end else begin
      state_q <= state_d;
      if (bus.mem_resp_valid && state_q != WAIT) stray_resp <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= pick;
`endif
            if (pick == GNT_LSU) begin
              addr_q  <= bus.lsu_addr;
              wen_q   <= bus.lsu_wen;
              wdata_q <= bus.lsu_wdata;
              wmask_q <= bus.lsu_wmask;
            end else begin
              addr_q  <= bus.ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        ISSUE: if (bus.mem_req_ready) cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_resp_valid) begin
            rdata_q <= bus.mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is gated by rst so a requester is never told it was accepted during reset.
  assign bus.ifu_req_ready  = (state_q == IDLE) && !rst && bus.ifu_req_valid && (pick == GNT_IFU);
  assign bus.lsu_req_ready  = (state_q == IDLE) && !rst && bus.lsu_req_valid && (pick == GNT_LSU);
  assign bus.ifu_resp_valid = (state_q == RESP) && (grant_q == GNT_IFU);
  assign bus.lsu_resp_valid = (state_q == RESP) && (grant_q == GNT_LSU);
  assign bus.ifu_resp_err   = bus.ifu_resp_valid && err_q;
  assign bus.lsu_resp_err   = bus.lsu_resp_valid && err_q;
  assign bus.ifu_rdata      = rdata_q;
  assign bus.lsu_rdata      = rdata_q;
  assign bus.mem_req_valid  = (state_q == ISSUE);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wen_q ? wmask_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter (TO_W=4).
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int TIMEOUT = 2 ** TW - 1;

  logic clk = 1'b0;
  logic rst;
  logic stray_resp;
  int   n_chk = 0;
  int   n_err = 0;
  bit   last_lsu = 1'b0;
  bit   stray_exp = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stray_resp (stray_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference arbitration: who should win given the valids and the previous winner.
  function automatic bit model_pick_lsu(input bit iv, input bit lv);
    bit conflict_lsu;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    conflict_lsu = !last_lsu;
`else
    conflict_lsu = 1'b1;
`endif
    if (iv && lv) return conflict_lsu;
    return lv;
  endfunction

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // One full transaction, entered at a negedge with the DUT in IDLE.
  // rsp_dly: WAIT cycle index on which memory answers; <0 or >=TIMEOUT means never.
  task automatic txn(input bit iv, input bit lv, input bit lw, input logic [63:0] ia,
                     input logic [63:0] la, input logic [63:0] wd, input logic [7:0] wm,
                     input int rdy_dly, input int rsp_dly, input logic [63:0] rd,
                     output bit got_lsu);
    bit wl, ew, timed, seen;
    logic [63:0] ea;
    int w, total, exp_w;
    wl = model_pick_lsu(iv, lv);
    last_lsu = wl;
    ea = wl ? la : ia;
    ew = wl && lw;
    timed = (rsp_dly < 0) || (rsp_dly >= TIMEOUT);
    exp_w = timed ? TIMEOUT : rsp_dly + 1;

    bus.ifu_req_valid = iv; bus.ifu_addr = ia;
    bus.lsu_req_valid = lv; bus.lsu_addr = la; bus.lsu_wen = lw;
    bus.lsu_wdata = wd; bus.lsu_wmask = wm;
    #1;
    got_lsu = bus.lsu_req_ready;
    check("ifu_req_ready", bus.ifu_req_ready, iv && !wl);
    check("lsu_req_ready", bus.lsu_req_ready, wl);
    @(negedge clk);
    total = 1;
    for (int r = 0; r <= rdy_dly; r++) begin
      bus.ifu_req_valid = 1'($urandom); bus.lsu_req_valid = 1'($urandom);
      bus.ifu_addr = {$urandom, $urandom}; bus.lsu_addr = {$urandom, $urandom};
      #1;
      check("issue_ifu_ready", bus.ifu_req_ready, 0);
      check("issue_lsu_ready", bus.lsu_req_ready, 0);
      check("mem_req_valid", bus.mem_req_valid, 1);
      check("mem_addr", bus.mem_addr, ea);
      check("mem_wen", bus.mem_wen, ew);
      check("mem_wmask", bus.mem_wmask, ew ? wm : 8'h00);
      if (ew) check("mem_wdata", bus.mem_wdata, wd);
      bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
      bus.mem_req_ready = (r == rdy_dly);
      @(negedge clk);
      total++;
    end
    bus.mem_req_ready = 1'b0;
    w = 0;
    seen = 1'b0;
    while (!seen && w < 40) begin
      bus.mem_resp_valid = (w == rsp_dly);
      bus.mem_rdata = (w == rsp_dly) ? rd : {$urandom, $urandom};
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      w++;
      total++;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) seen = 1'b1;
    end
    check("resp_seen", seen, 1);
    check("latency", total, rdy_dly + 2 + exp_w);
    check("ifu_resp_valid", bus.ifu_resp_valid, !wl);
    check("lsu_resp_valid", bus.lsu_resp_valid, wl);
    check("resp_err", wl ? bus.lsu_resp_err : bus.ifu_resp_err, timed);
    check("resp_rdata", wl ? bus.lsu_rdata : bus.ifu_rdata, timed ? 64'h0 : rd);
    @(negedge clk);
    check("resp_one_cycle", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("stray_resp", stray_resp, stray_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit gl;
    bit exp_rr[4];
    rst = 1'b1;
    clear_inputs();
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    #1;
    check("rst_ifu_ready", bus.ifu_req_ready, 0);
    check("rst_lsu_ready", bus.lsu_req_ready, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_stray", stray_resp, 0);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single IFU read, best-case latency
    txn(1, 0, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 64'h1122334455667788, gl);
    // LSU write
    txn(0, 1, 1, 0, 64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 1, 2, 64'h55, gl);

    // Conflicts, 4 rounds
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_rr = '{1, 0, 1, 0};
    last_lsu = 1'b0;
    // Reset-to-IFU history is what makes the first conflict go LSU; re-establish it.
    txn(1, 0, 0, 64'h100, 0, 0, 0, 0, 0, 64'h1, gl);
`else
    exp_rr = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, 0, 64'h200 + 64'(i), 64'h300 + 64'(i), 0, 8'hFF, 0, 1, 64'(i), gl);
      check("arb_round", gl, exp_rr[i]);
    end

    // Watchdog, then normal service
    txn(0, 1, 0, 0, 64'h8000_0040, 0, 0, 0, -1, 64'hAA, gl);
    txn(1, 0, 0, 64'h8000_0080, 0, 0, 0, 2, 14, 64'h0123456789ABCDEF, gl);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit iv, lv;
      iv = 1'($urandom);
      lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      txn(iv, lv, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 17)), {$urandom, $urandom}, gl);
    end

    // Stray response in IDLE
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 64'hFFFF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    stray_exp = 1'b1;
    check("stray_set", stray_resp, 1);
    check("stray_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    @(negedge clk);
    check("stray_no_resp2", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    txn(0, 1, 0, 0, 64'h900, 0, 0, 0, 3, 64'h77, gl);

    // Reset during WAIT
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr = 64'h8000_1000;
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_req_valid", bus.mem_req_valid, 0);
    check("arst_resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_stray", stray_resp, 0);
    stray_exp = 1'b0;
    last_lsu = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("late_stray", stray_resp, 1);
    for (int i = 0; i < 3; i++) begin
      check("late_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
      @(negedge clk);
    end
    check("late_stray_hold", stray_resp, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
